// File: rtl/led_serial_tx_pkg.sv
// Shared types for the LED serial output stage.
// Holds the colour word type and its width.
package led_serial_tx_pkg;

   localparam int LED_COLOUR_W = 24;

   typedef logic [LED_COLOUR_W-1:0] rgb_t;

endpackage

// File: rtl/led_bit_timer.sv
// Serial bit timer: divides clk into one bit period of 2*CLK_DIV cycles.
// Ports: clk_i, rst_i, run_i (count enable), clk_out_o (serial clock),
// bit_end_o (last cycle of the current bit).
module led_bit_timer
   import led_serial_tx_pkg::*;
#(
   parameter int CLK_DIV = 4
)
(
   input  logic clk_i,
   input  logic rst_i,
   input  logic run_i,
   output logic clk_out_o,
   output logic bit_end_o
);

   localparam int DW = $clog2(2 * CLK_DIV);
   localparam logic [DW-1:0] HALF = DW'(CLK_DIV);
   localparam logic [DW-1:0] LAST = DW'(2 * CLK_DIV - 1);

   logic [DW-1:0] div_q;
   logic [DW-1:0] div_d;
   logic          clk_q;
   logic          clk_d;

   assign bit_end_o = run_i && (div_q == LAST);
   assign clk_out_o = clk_q;

   // clk_q tracks the phase of the count it will sit beside, so the
   // serial clock falls on the same edge the bit ends.
   always_comb begin
      div_d = '0;
      if (run_i && !bit_end_o) begin
         div_d = div_q + 1'b1;
      end
      clk_d = run_i && !bit_end_o && (div_d >= HALF);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         div_q <= '0;
         clk_q <= 1'b0;
      end else begin
         div_q <= div_d;
         clk_q <= clk_d;
      end
   end

endmodule

// File: rtl/led_serial_tx.sv
// Fetches one frame of 24-bit colours and shifts it out MSB first to a
// two-wire LED strip, then holds a latch gap and raises done.
// Ports: clk, rst, start, rgb (buffer data), rdEn/rdAddr (buffer read),
// dOut/clkOut (strip), done (idle / frame complete).
module led_serial_tx
   import led_serial_tx_pkg::*;
#(
   parameter int LEDS         = 50,
   parameter int CLK_DIV      = 4,
   parameter int LATCH_CYCLES = 6250
)
(
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start,
   input  logic [LED_COLOUR_W-1:0]   rgb,
   output logic                      rdEn,
   output logic [$clog2(LEDS)-1:0]   rdAddr,
   output logic                      dOut,
   output logic                      clkOut,
   output logic                      done
);

   localparam int AW = $clog2(LEDS);
   localparam int LW = $clog2(LATCH_CYCLES + 1);
   localparam logic [AW-1:0] LAST_LED  = AW'(LEDS - 1);
   localparam logic [LW-1:0] LATCH_END = LW'(LATCH_CYCLES);
   localparam logic [4:0]    LAST_BIT  = 5'(LED_COLOUR_W - 1);

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      SHIFT,
      LATCH,
      DONE
   } state_e;

   state_e          state_q;
   rgb_t            shreg_q;
   logic [4:0]      bit_q;
   logic [LW-1:0]   latch_q;
   logic [AW-1:0]   addr_q;
   logic            rden_q;
   logic            done_q;
   logic            run;
   logic            bit_end;

   assign run = (state_q == SHIFT);

   led_bit_timer #(
      .CLK_DIV (CLK_DIV)
   ) u_timer (
      .clk_i     (clk),
      .rst_i     (rst),
      .run_i     (run),
      .clk_out_o (clkOut),
      .bit_end_o (bit_end)
   );

   // The shifter empties to zero after 24 shifts, so dOut is already
   // low through FETCH and LATCH without a separate data register.
   assign dOut   = shreg_q[LED_COLOUR_W-1];
   assign rdEn   = rden_q;
   assign rdAddr = addr_q;
   assign done   = done_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         shreg_q <= '0;
         bit_q   <= '0;
         latch_q <= '0;
         addr_q  <= '0;
         rden_q  <= 1'b0;
         done_q  <= 1'b1;
      end else begin
         rden_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               done_q <= 1'b1;
               if (start) begin
                  state_q <= FETCH;
                  addr_q  <= '0;
                  rden_q  <= 1'b1;
                  done_q  <= 1'b0;
               end
            end
            FETCH: begin
               shreg_q <= rgb;
               bit_q   <= '0;
               state_q <= SHIFT;
            end
            SHIFT: begin
               if (bit_end) begin
                  shreg_q <= {shreg_q[LED_COLOUR_W-2:0], 1'b0};
                  bit_q   <= bit_q + 5'd1;
                  if (bit_q == LAST_BIT) begin
                     if (addr_q == LAST_LED) begin
                        state_q <= LATCH;
                        latch_q <= '0;
                     end else begin
                        addr_q  <= addr_q + 1'b1;
                        rden_q  <= 1'b1;
                        state_q <= FETCH;
                     end
                  end
               end
            end
            LATCH: begin
               // Count runs through LATCH_CYCLES inclusive; the extra
               // cycle covers the edge where the last bit's clock falls.
               if (latch_q == LATCH_END) begin
                  state_q <= DONE;
                  done_q  <= 1'b1;
               end else begin
                  latch_q <= latch_q + 1'b1;
               end
            end
            DONE: begin
               done_q <= 1'b1;
               if (!start) begin
                  state_q <= IDLE;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_led_serial_tx.sv
// Scoreboard bench for led_serial_tx: a small config (2 LEDs) and the
// default config, checked bit-by-bit at every serial clock rise.
module tb_led_serial_tx;
   import led_serial_tx_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int errors = 0;
   int checks = 0;

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                  nm, act, exp, cyc);
      end
   endtask

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   // ---------------- small configuration ----------------
   logic       rst   = 1'b1;
   logic       start = 1'b0;
   rgb_t       rgb   = '0;
   logic       rdEn;
   logic [0:0] rdAddr;
   logic       dOut;
   logic       clkOut;
   logic       done;

   led_serial_tx #(
      .LEDS         (2),
      .CLK_DIV      (1),
      .LATCH_CYCLES (8)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .rgb    (rgb),
      .rdEn   (rdEn),
      .rdAddr (rdAddr),
      .dOut   (dOut),
      .clkOut (clkOut),
      .done   (done)
   );

   rgb_t mem [2] = '{24'hFF0000, 24'h00A5C3};

   // Registered buffer: data only valid the cycle after rdEn, junk otherwise.
   always @(negedge clk) begin
      rgb = (rdEn === 1'b1) ? mem[rdAddr] : (24'h5A5A5A ^ 24'(cyc));
   end

   bit   q [$];
   int   rises = 0;
   int   rden_cnt = 0;
   int   first_rise = -1;
   logic pclk = 1'b0;
   logic pd = 1'b0;

   always @(negedge clk) begin
      if (rdEn === 1'b1) rden_cnt++;
      if (clkOut === 1'b1 && pclk === 1'b0) begin
         rises++;
         if (first_rise < 0) first_rise = cyc;
         if (q.size() == 0) chk("rise_unexpected", 1, 0);
         else chk("dout_bit", int'(dOut), int'(q.pop_front()));
      end else if (clkOut === 1'b1 && pclk === 1'b1) begin
         chk("dout_stable_hi", int'(dOut), int'(pd));
      end
      pclk = clkOut;
      pd   = dOut;
   end

   task automatic push_frame();
      for (int i = 0; i < 2; i++)
         for (int b = 23; b >= 0; b--) q.push_back(mem[i][b]);
   endtask

   task automatic send_frame(input string nm, input bit pulse);
      int c0;
      int r0;
      int e0;
      int low;
      bit seen;
      push_frame();
      r0 = rises;
      e0 = rden_cnt;
      first_rise = -1;
      start = 1'b1;
      c0 = cyc + 1;
      step();
      chk({nm, "_done_low"}, int'(done), 0);
      if (pulse) start = 1'b0;
      low = 0;
      seen = 0;
      for (int i = 0; i < 400; i++) begin
         if (done === 1'b1) begin
            seen = 1;
            break;
         end
         low = (clkOut === 1'b0 && dOut === 1'b0) ? low + 1 : 0;
         step();
      end
      chk({nm, "_done_seen"}, int'(seen), 1);
      chk({nm, "_latency"}, cyc - c0, 107);
      chk({nm, "_latch_low"}, int'(low >= 8), 1);
      chk({nm, "_first_rise"}, first_rise - c0, 2);
      chk({nm, "_rises"}, rises - r0, 48);
      chk({nm, "_rden"}, rden_cnt - e0, 2);
      chk({nm, "_queue"}, q.size(), 0);
   endtask

   // ---------------- default configuration ----------------
   logic       rst2   = 1'b1;
   logic       start2 = 1'b0;
   rgb_t       rgb2   = '0;
   logic       rdEn2;
   logic [5:0] rdAddr2;
   logic       dOut2;
   logic       clkOut2;
   logic       done2;

   led_serial_tx dutd (
      .clk    (clk),
      .rst    (rst2),
      .start  (start2),
      .rgb    (rgb2),
      .rdEn   (rdEn2),
      .rdAddr (rdAddr2),
      .dOut   (dOut2),
      .clkOut (clkOut2),
      .done   (done2)
   );

   function automatic rgb_t pat(input int i);
      return {8'(i), 8'hA5 ^ 8'(i), 8'(3 * i)};
   endfunction

   always @(negedge clk) begin
      rgb2 = (rdEn2 === 1'b1) ? pat(int'(rdAddr2)) : (24'hC3C3C3 ^ 24'(cyc));
   end

   bit   q2 [$];
   int   rises2 = 0;
   int   rden2 = 0;
   int   last2 = 0;
   logic pclk2 = 1'b0;

   always @(negedge clk) begin
      if (rdEn2 === 1'b1) begin
         chk("rdaddr_step", int'(rdAddr2), rden2);
         rden2++;
      end
      if (clkOut2 === 1'b1 && pclk2 === 1'b0) begin
         if (q2.size() == 0) chk("rise2_unexpected", 1, 0);
         else chk("dout2_bit", int'(dOut2), int'(q2.pop_front()));
         if (rises2 > 0)
            chk("clk2_period", cyc - last2, (rises2 % 24 == 0) ? 9 : 8);
         last2 = cyc;
         rises2++;
      end
      pclk2 = clkOut2;
   end

   // ---------------- sequence ----------------
   initial begin
      int r0;
      int e0;
      int c0;
      int low;
      bit seen;

      repeat (3) step();
      rst  = 1'b0;
      rst2 = 1'b0;
      step();
      chk("rst_dout", int'(dOut), 0);
      chk("rst_clkout", int'(clkOut), 0);
      chk("rst_rden", int'(rdEn), 0);
      chk("rst_rdaddr", int'(rdAddr), 0);
      chk("rst_done", int'(done), 1);

      // frame with start held high throughout
      send_frame("held", 0);

      // start still high: no retrigger
      r0 = rises;
      e0 = rden_cnt;
      repeat (200) step();
      chk("hold_no_rises", rises - r0, 0);
      chk("hold_no_rden", rden_cnt - e0, 0);
      chk("hold_done", int'(done), 1);

      start = 1'b0;
      step();
      send_frame("again", 0);
      start = 1'b0;
      repeat (2) step();

      // reset during bit 10 of LED 1
      push_frame();
      while (q.size() > 34) void'(q.pop_back());
      r0 = rises;
      start = 1'b1;
      seen = 0;
      for (int i = 0; i < 400; i++) begin
         step();
         if (rises - r0 == 34) begin
            seen = 1;
            break;
         end
      end
      chk("mid_reached", int'(seen), 1);
      start = 1'b0;
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("mid_rst_dout", int'(dOut), 0);
      chk("mid_rst_clkout", int'(clkOut), 0);
      chk("mid_rst_done", int'(done), 1);
      chk("mid_rst_rden", int'(rdEn), 0);
      repeat (3) step();
      chk("mid_rst_rises", rises - r0, 34);
      chk("mid_rst_queue", q.size(), 0);

      send_frame("after_rst", 0);
      start = 1'b0;
      repeat (2) step();

      // single-cycle start pulse
      send_frame("pulse", 1);
      step();
      chk("pulse_done_hold", int'(done), 1);
      e0 = rden_cnt;
      repeat (20) step();
      chk("pulse_idle_rden", rden_cnt - e0, 0);
      chk("pulse_idle_done", int'(done), 1);

      // default configuration, full 50-LED frame
      for (int i = 0; i < 50; i++) begin
         rgb_t w;
         w = pat(i);
         for (int b = 23; b >= 0; b--) q2.push_back(w[b]);
      end
      start2 = 1'b1;
      c0 = cyc + 1;
      step();
      start2 = 1'b0;
      chk("def_done_low", int'(done2), 0);
      low = 0;
      seen = 0;
      for (int i = 0; i < 20000; i++) begin
         if (done2 === 1'b1) begin
            seen = 1;
            break;
         end
         low = (clkOut2 === 1'b0 && dOut2 === 1'b0) ? low + 1 : 0;
         step();
      end
      chk("def_done_seen", int'(seen), 1);
      chk("def_latency", cyc - c0, 15901);
      chk("def_latch_low", int'(low >= 6250), 1);
      chk("def_rises", rises2, 1200);
      chk("def_rden", rden2, 50);
      chk("def_queue", q2.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/led_serial_tx.md
Name: led_serial_tx

Overview:
- Output stage directly downstream of the light-visualisation colour stage. Takes one frame of per-LED 24-bit colour words from a registered colour buffer and clocks them out to a WS2801-style two-wire strip on clkOut/dOut.
- Ends each frame with a low-clock latch interval, then reports completion on a level `done` handshake.
- Colour computation is upstream; this block only fetches, serialises and times.

Parameters:
- LEDS, 50, number of LEDs per frame.
- CLK_DIV, 4, system clocks per half serial-bit period (clkOut low CLK_DIV cycles, then high CLK_DIV cycles).
- LATCH_CYCLES, 6250, system clocks clkOut is held low after the last bit (500 us at 12.5 MHz).

Ports:
- clk  in  1  system clock, 12.5 MHz nominal.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  level request to send one frame.
- rgb  in  24  colour word for the LED at rdAddr, valid one cycle after rdEn. Bits {R[23:16],G[15:8],B[7:0]}.
- rdEn  out  1  colour buffer read strobe.
- rdAddr  out  $clog2(LEDS)  LED index being read.
- dOut  out  1  serial data, MSB first.
- clkOut  out  1  serial clock; the strip samples dOut on the rising edge.
- done  out  1  high when idle or frame complete; low while a frame is in progress.

Behaviour:
- Reset values: dOut=0, clkOut=0, rdEn=0, rdAddr=0, done=1, state=IDLE, all counters 0.
- All outputs are registered.
- State machine:
  - IDLE: done=1. On start=1, go to FETCH, set rdAddr=0, pulse rdEn, and drive done=0 from the next cycle.
  - FETCH: exactly 1 cycle. At the end, load rgb into a 24-bit shift register, bitCnt=0, divCnt=0.
  - SHIFT:
    - dOut = shreg[23] throughout the bit; clkOut=0 for divCnt 0..CLK_DIV-1 and 1 for CLK_DIV..2*CLK_DIV-1.
    - At bit end, clkOut falls, the shift register moves left and bitCnt increments.
    - After bit 23: if rdAddr==LEDS-1, go to LATCH. Otherwise rdAddr++, pulse rdEn, go to FETCH.
  - LATCH: clkOut=0, dOut=0 for LATCH_CYCLES cycles, then go to DONE.
  - DONE: done=1. Stay while start=1. When start=0, go to IDLE.
- dOut changes only while clkOut is low (at the falling edge or at load). It is never changed in the same cycle clkOut rises.
- clkOut is low during FETCH; the extra low cycle between LEDs is tolerated by the strip.
- Latency:
  - The first clkOut rise is CLK_DIV+1 cycles after the FETCH entry edge.
  - Per LED: 1 + 2*24*CLK_DIV cycles.
  - done=1 again exactly 1 + LEDS*(1+48*CLK_DIV) + LATCH_CYCLES cycles after the edge that sampled start=1.
- start dropping mid-frame is ignored; the frame completes. start still high at DONE does not retrigger a frame; it must be seen low first.
- rst mid-frame aborts on the next edge to the reset values. No latch interval is generated and the strip shows garbage until the next frame.
- rgb is sampled only at the FETCH-end edge; changes at other times have no effect.
- Counter widths: divCnt $clog2(2*CLK_DIV), bitCnt 5 bits, latchCnt $clog2(LATCH_CYCLES+1). Counters never wrap inside a state.

Decomposition:
- CCHW package: add the RGB typedef (logic [23:0]) and the constant LED_COLOUR_W=24. The state enum stays local to the module.
- One sub-module is natural: led_bit_timer (divCnt, clkOut phase, bitEnd pulse). The FSM and shift register stay in led_serial_tx.

Test Plan:
- LEDS=2, CLK_DIV=1, LATCH_CYCLES=8, rgb[0]=24'hFF0000, rgb[1]=24'h00A5C3, start held -> exactly 48 clkOut rises. dOut sampled at rises = 8 ones, 16 zeros, then bits of 00A5C3 MSB first.
- Same config, count cycles -> done low from the cycle after start is sampled, high again exactly 1+2*49+8=107 cycles after the start edge. clkOut and dOut are 0 for the final 8 cycles before done rises.
- Same config, start held after done -> no further rdEn or clkOut activity for 200 cycles. Drop start for 1 cycle, raise it -> second identical frame.
- rst asserted for 1 cycle at bit 10 of LED 1 -> next edge dOut=0, clkOut=0, done=1, rdEn=0. A later start produces a complete 48-bit frame.
- Defaults (LEDS=50, CLK_DIV=4) -> 1200 clkOut rises, clkOut period 8 cycles (640 ns). Latch low ≥6250 cycles. rdAddr steps 0..49 with exactly 50 rdEn pulses.
- 1-cycle start pulse -> full frame sent; DONE exits to IDLE on the next edge; done remains 1.
